countdown_timer_8bit: RTL and testbench
=======================================

Name: countdown_timer_8bit

Overview:
- 8-bit loadable down-counter/timer; the decrementing counterpart of the team's 8-bit up counter.
- Software or the sequencer sets a reload value, then starts it. The block counts down on qualified trigger ticks to zero.
- It emits a one-cycle done pulse at terminal count, in one-shot or periodic (auto-reload) mode.
- Used for delays, timeouts and periodic event generation in the common_module library.

Parameters:
- PRESCALE, 4, trigger ticks per decrement; legal range 1..256. Used only when COUNTDOWN_PRESCALE_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_set  input  1  load i_data into the reload register and the counter.
- i_data  input  8  reload value.
- i_start  input  1  start or resume counting.
- i_stop  input  1  pause counting.
- i_mode  input  1  0 = one-shot, 1 = periodic auto-reload. Sampled every cycle.
- i_trigger  input  1  count-enable tick.
- o_number  output  8  current counter value, registered.
- o_busy  output  1  high while in RUN.
- o_done  output  1  one-cycle pulse at terminal count, registered.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - o_number=0, reload=0, o_busy=0, o_done=0.
  - State = IDLE; prescaler = 0.
- States: IDLE, RUN. o_busy = (state==RUN), registered.
- Per-cycle priority: i_set > i_stop > i_start > tick.
- i_set (any state):
  - reload<=i_data, counter<=i_data, state<=IDLE.
  - o_done<=0; prescaler cleared.
- i_stop:
  - RUN -> IDLE; counter holds its value (pause).
  - In IDLE, no effect.
- i_start in IDLE:
  - counter!=0: resume from current counter value; state<=RUN.
  - counter==0 and reload!=0: counter<=reload; state<=RUN.
  - counter==0 and reload==0: zero-length period. o_done pulses next cycle; state stays IDLE.
- i_start while in RUN: ignored.
- Tick in RUN:
  - Tick = i_trigger=1 (or the prescaled tick, see Optional Feature).
  - counter>1: counter<=counter-1.
  - counter==1, one-shot: counter<=0, state<=IDLE, o_done<=1.
  - counter==1, periodic: counter<=reload, state stays RUN, o_done<=1.
  - Periodic with reload==1: o_done pulses every tick; counter stays 1.
- i_trigger in IDLE: ignored; counter holds.
- Latency:
  - o_number updates on the edge that samples the tick.
  - o_done is high the cycle after the terminal tick, for exactly one cycle unless the next tick terminates again.
- Arithmetic:
  - 8-bit unsigned. No wrap below 0; counter never decrements from 0.
  - RUN with counter==0 cannot occur.
- Simultaneous events:
  - i_set with a terminal tick: i_set wins, no o_done.
  - i_stop with a terminal tick: stop wins; counter stays 1, no o_done.
- Reset mid-count: everything returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: COUNTDOWN_PRESCALE_EN.
- Defined:
  - An 8-bit prescaler counts i_trigger pulses while in RUN.
  - A decrement tick occurs on the PRESCALE-th i_trigger; the prescaler then returns to 0.
  - The prescaler is cleared on reset, i_set, i_stop and on entry to RUN.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic; every i_trigger in RUN is a tick; PRESCALE is ignored.

Test Plan:
- i_set, i_data=8'h03, i_mode=0; i_start; i_trigger held high.
  -> o_busy=1; o_number 3,2,1,0 on successive edges.
  -> o_done=1 for exactly one cycle after the edge that makes o_number 0; then o_busy=0.
- i_data=8'h02, i_mode=1, start, i_trigger high for 6 cycles.
  -> o_number sequence 2,1,2,1,2,1; o_done pulses 3 times; o_busy stays 1.
- i_data=8'h05, start, 2 ticks (o_number=3), i_stop, 3 idle triggers, i_start, ticks.
  -> o_number holds 3 while IDLE, then resumes 2,1,0 with a single o_done.
- i_data=8'h00, i_start.
  -> o_done=1 for one cycle, o_busy stays 0, o_number=0.
- Terminal tick at counter=1 together with i_set, i_data=8'h10.
  -> o_number=8'h10, state IDLE, o_done=0.
- rst_n asserted low mid-count with counter at 8'h40.
  -> o_number=0, o_busy=0, o_done=0 immediately, without waiting for a clk edge.
  -> Also with COUNTDOWN_PRESCALE_EN and PRESCALE=4, data=2: o_done occurs after exactly 8 i_trigger pulses.

Source files
------------

// File: rtl/countdown_timer_8bit_if.sv
// Control/status bundle for countdown_timer_8bit.
// The master drives the commands and the trigger. The slave (the timer) returns count, busy and done.
interface countdown_timer_8bit_if;
  logic       i_set;
  logic [7:0] i_data;
  logic       i_start;
  logic       i_stop;
  logic       i_mode;
  logic       i_trigger;
  logic [7:0] o_number;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_set, i_data, i_start, i_stop, i_mode, i_trigger,
    input  o_number, o_busy, o_done
  );

  modport slave (
    input  i_set, i_data, i_start, i_stop, i_mode, i_trigger,
    output o_number, o_busy, o_done
  );
endinterface

// File: rtl/countdown_timer_8bit.sv
// 8-bit loadable down-counter with one-shot / periodic reload and a registered done pulse.
// Optional trigger prescaler is enabled by defining COUNTDOWN_PRESCALE_EN.
module countdown_timer_8bit #(
  parameter int unsigned PRESCALE = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  countdown_timer_8bit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] counter;
  logic [7:0] reload;
  logic       done;
  logic       tick;

  if (PRESCALE < 1 || PRESCALE > 256) begin : g_prescale_range
    $error("countdown_timer_8bit: PRESCALE must be within 1..256");
  end

`ifdef COUNTDOWN_PRESCALE_EN
  localparam logic [7:0] PRESCALE_LAST = 8'(PRESCALE - 1);

  logic [7:0] prescaler;

  always_comb begin
    tick = 1'b0;
    if (bus.i_trigger && (prescaler == PRESCALE_LAST)) tick = 1'b1;
  end

  // The prescaler only advances on cycles where the tick branch below is reached.
  // Set, stop and entry to RUN all clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (bus.i_set || bus.i_stop) begin
      prescaler <= '0;
    end else if (bus.i_start && state == IDLE) begin
      prescaler <= '0;
    end else if (state == RUN && bus.i_trigger) begin
      prescaler <= tick ? '0 : prescaler + 8'd1;
    end
  end
`else
  assign tick = bus.i_trigger;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      reload  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.i_set) begin
        reload  <= bus.i_data;
        counter <= bus.i_data;
        state   <= IDLE;
      end else if (bus.i_stop) begin
        state <= IDLE;
      end else if (bus.i_start && state == IDLE) begin
        if (counter != 8'd0) begin
          state <= RUN;
        end else if (reload != 8'd0) begin
          counter <= reload;
          state   <= RUN;
        end else begin
          done <= 1'b1;
        end
      end else if (state == RUN && tick) begin
        if (counter > 8'd1) begin
          counter <= counter - 8'd1;
        end else begin
          done <= 1'b1;
          if (bus.i_mode) begin
            counter <= reload;
          end else begin
            counter <= '0;
            state   <= IDLE;
          end
        end
      end
    end
  end

  assign bus.o_number = counter;
  assign bus.o_busy   = (state == RUN);
  assign bus.o_done   = done;

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// Randomized and directed bench for countdown_timer_8bit against a rule-level reference model.
module tb_countdown_timer_8bit;

  localparam int unsigned PRESCALE = 4;
`ifdef COUNTDOWN_PRESCALE_EN
  localparam int unsigned TRIGS_PER_TICK = PRESCALE;
`else
  localparam int unsigned TRIGS_PER_TICK = 1;
`endif

  logic clk;
  logic rst_n;
  countdown_timer_8bit_if bus_if ();

  countdown_timer_8bit #(.PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the counter value, the reload value, whether the timer is running,
  // the pending done pulse, and triggers seen since the last decrement.
  int m_cnt, m_rel, m_trigs;
  bit m_run, m_done;

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_trigs = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_step(input bit set, input int data, input bit start,
                            input bit stop, input bit mode, input bit trig);
    bit nd;
    nd = 0;
    if (set) begin
      m_rel = data; m_cnt = data; m_run = 0; m_trigs = 0;
    end else if (stop) begin
      m_run = 0; m_trigs = 0;
    end else if (start && !m_run) begin
      m_trigs = 0;
      if (m_cnt != 0) m_run = 1;
      else if (m_rel != 0) begin m_cnt = m_rel; m_run = 1; end
      else nd = 1;
    end else if (m_run && trig) begin
      m_trigs++;
      if (m_trigs == TRIGS_PER_TICK) begin
        m_trigs = 0;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          nd = 1;
          if (mode) m_cnt = m_rel;
          else begin m_cnt = 0; m_run = 0; end
        end
      end
    end
    m_done = nd;
  endtask

  // One clock: drive inputs, step the model on the edge, compare shortly after.
  task automatic cyc(input bit set, input int data, input bit start,
                     input bit stop, input bit mode, input bit trig, input string tag);
    bus_if.i_set     = set;
    bus_if.i_data    = 8'(data);
    bus_if.i_start   = start;
    bus_if.i_stop    = stop;
    bus_if.i_mode    = mode;
    bus_if.i_trigger = trig;
    @(posedge clk);
    model_step(set, data, start, stop, mode, trig);
    #1;
    check({tag, ".number"}, 32'(bus_if.o_number), 32'(m_cnt));
    check({tag, ".busy"},   32'(bus_if.o_busy),   32'(m_run));
    check({tag, ".done"},   32'(bus_if.o_done),   32'(m_done));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.number", 32'(bus_if.o_number), 32'd0);
    check("reset.busy",   32'(bus_if.o_busy),   32'd0);
    check("reset.done",   32'(bus_if.o_done),   32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int dones, trig_cnt, guard;
  bit r_set, r_start, r_stop, r_trig;
  int r_data;
  bit r_mode;

  initial begin
    bus_if.i_set = 0; bus_if.i_data = '0; bus_if.i_start = 0;
    bus_if.i_stop = 0; bus_if.i_mode = 0; bus_if.i_trigger = 0;
    do_reset();

    // One-shot from 3.
    cyc(1, 3, 0, 0, 0, 0, "os.set");
    cyc(0, 0, 1, 0, 0, 1, "os.start");
    for (int i = 0; i < 4 * TRIGS_PER_TICK + 2; i++) cyc(0, 0, 0, 0, 0, 1, "os.run");

    // Periodic from 2.
    cyc(1, 2, 0, 0, 1, 0, "per.set");
    cyc(0, 0, 1, 0, 1, 0, "per.start");
    dones = 0;
    for (int i = 0; i < 6 * TRIGS_PER_TICK; i++) begin
      cyc(0, 0, 0, 0, 1, 1, "per.run");
      if (bus_if.o_done) dones++;
    end
    check("per.done_count", 32'(dones), 32'd3);

    // Pause and resume from 5.
    cyc(1, 5, 0, 0, 0, 0, "pause.set");
    cyc(0, 0, 1, 0, 0, 0, "pause.start");
    for (int i = 0; i < 2 * TRIGS_PER_TICK; i++) cyc(0, 0, 0, 0, 0, 1, "pause.tick");
    check("pause.at3", 32'(bus_if.o_number), 32'd3);
    cyc(0, 0, 0, 1, 0, 1, "pause.stop");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, "pause.idle_trig");
    cyc(0, 0, 1, 0, 0, 0, "pause.resume");
    dones = 0;
    for (int i = 0; i < 3 * TRIGS_PER_TICK + 2; i++) begin
      cyc(0, 0, 0, 0, 0, 1, "pause.run");
      if (bus_if.o_done) dones++;
    end
    check("pause.done_count", 32'(dones), 32'd1);

    // Zero-length period.
    cyc(1, 0, 0, 0, 0, 0, "zero.set");
    cyc(0, 0, 1, 0, 0, 0, "zero.start");
    check("zero.done_pulse", 32'(bus_if.o_done), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, "zero.after");

    // Set colliding with the terminal tick.
    cyc(1, 4, 0, 0, 0, 0, "setcol.set");
    cyc(0, 0, 1, 0, 0, 0, "setcol.start");
    guard = 0;
    while (!(m_cnt == 1 && m_trigs == TRIGS_PER_TICK - 1) && guard < 100) begin
      cyc(0, 0, 0, 0, 0, 1, "setcol.run"); guard++;
    end
    check("setcol.reached", 32'(guard < 100), 32'd1);
    cyc(1, 8'h10, 0, 0, 0, 1, "setcol.hit");
    check("setcol.number", 32'(bus_if.o_number), 32'h10);

    // Stop colliding with the terminal tick.
    cyc(0, 0, 1, 0, 0, 0, "stopcol.start");
    guard = 0;
    while (!(m_cnt == 1 && m_trigs == TRIGS_PER_TICK - 1) && guard < 200) begin
      cyc(0, 0, 0, 0, 0, 1, "stopcol.run"); guard++;
    end
    check("stopcol.reached", 32'(guard < 200), 32'd1);
    cyc(0, 0, 0, 1, 0, 1, "stopcol.hit");
    check("stopcol.number", 32'(bus_if.o_number), 32'd1);

    // Done arrives after exactly data*prescale triggers.
    cyc(1, 2, 0, 0, 0, 0, "psc.set");
    cyc(0, 0, 1, 0, 0, 0, "psc.start");
    trig_cnt = 0;
    guard = 0;
    while (!bus_if.o_done && guard < 100) begin
      cyc(0, 0, 0, 0, 0, 1, "psc.run"); trig_cnt++; guard++;
    end
    check("psc.trigger_count", 32'(trig_cnt), 32'(2 * TRIGS_PER_TICK));

    // Asynchronous reset mid-count at 0x40.
    cyc(1, 8'h60, 0, 0, 0, 0, "arst.set");
    cyc(0, 0, 1, 0, 0, 0, "arst.start");
    guard = 0;
    while (m_cnt != 8'h40 && guard < 1000) begin
      cyc(0, 0, 0, 0, 0, 1, "arst.run"); guard++;
    end
    check("arst.at40", 32'(bus_if.o_number), 32'h40);
    bus_if.i_trigger = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.number", 32'(bus_if.o_number), 32'd0);
    check("arst.busy",   32'(bus_if.o_busy),   32'd0);
    check("arst.done",   32'(bus_if.o_done),   32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r_set   = ($urandom_range(0, 99) < 4);
      r_stop  = ($urandom_range(0, 99) < 4);
      r_start = ($urandom_range(0, 99) < 10);
      r_trig  = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
      r_data  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 6));
      cyc(r_set, r_data, r_start, r_stop, r_mode, r_trig, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
